// File: rtl/aes128_job_ctrl.sv
// Job controller for the aes128 core: accepts one block over valid/ready, pulses the
// core enable, waits for the core_ready rising edge (with watchdog) and returns the result.
module aes128_job_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TMO_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_decrypt,
    input  logic         s_first,
    input  logic [127:0] cfg_key,
    input  logic [3:0]   cfg_mode,
    input  logic [127:0] cfg_iv,
    input  logic [15:0]  cfg_seg_len,
    output logic         core_cipher_en,
    output logic         core_decipher_en,
    output logic         core_chain_en,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    output logic [3:0]   core_mode,
    output logic [127:0] core_iv,
    output logic [15:0]  core_seg_len,
    input  logic [127:0] core_data_out,
    input  logic         core_ready,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_err,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q,   state_d;
    logic [127:0]     data_q,    data_d;
    logic [127:0]     key_q,     key_d;
    logic [3:0]       mode_q,    mode_d;
    logic [127:0]     iv_q,      iv_d;
    logic [15:0]      seg_len_q, seg_len_d;
    logic             decrypt_q, decrypt_d;
    logic             first_q,   first_d;
    logic             ready_d_q;
    logic [TMO_W-1:0] cnt_q,     cnt_d;
    logic [127:0]     m_data_q,  m_data_d;
    logic             m_err_q,   m_err_d;
    logic             ready_rise;

    // Handshake, enable and chain outputs are decoded straight from the state register.
    assign s_ready          = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign m_valid          = (state_q == S_OUT);
    assign core_cipher_en   = (state_q == S_START) && !decrypt_q;
    assign core_decipher_en = (state_q == S_START) &&  decrypt_q;
    assign core_chain_en    = (state_q != S_IDLE) && !first_q;
    assign core_data_in     = data_q;
    assign core_key         = key_q;
    assign core_mode        = mode_q;
    assign core_iv          = iv_q;
    assign core_seg_len     = seg_len_q;
    assign m_data           = m_data_q;
    assign m_err            = m_err_q;

    assign ready_rise = core_ready && !ready_d_q;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        key_d     = key_q;
        mode_d    = mode_q;
        iv_d      = iv_q;
        seg_len_d = seg_len_q;
        decrypt_d = decrypt_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_err_d   = m_err_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    data_d    = s_data;
                    key_d     = cfg_key;
                    mode_d    = cfg_mode;
                    iv_d      = cfg_iv;
                    seg_len_d = cfg_seg_len;
                    decrypt_d = s_decrypt;
                    first_d   = s_first;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A rising edge beats a watchdog expiry in the same cycle.
                if (ready_rise) begin
                    m_data_d = core_data_out;
                    m_err_d  = 1'b0;
                    state_d  = S_OUT;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    m_data_d = '0;
                    m_err_d  = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            S_OUT: begin
                if (m_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            key_q     <= '0;
            mode_q    <= '0;
            iv_q      <= '0;
            seg_len_q <= '0;
            decrypt_q <= 1'b0;
            first_q   <= 1'b0;
            ready_d_q <= 1'b0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            key_q     <= key_d;
            mode_q    <= mode_d;
            iv_q      <= iv_d;
            seg_len_q <= seg_len_d;
            decrypt_q <= decrypt_d;
            first_q   <= first_d;
            ready_d_q <= core_ready;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_err_q   <= m_err_d;
        end
    end

endmodule

// File: tb/tb_aes128_job_ctrl.sv
// Bench for aes128_job_ctrl: stub aes128 core answering known vectors, table-driven
// jobs, hand-written corner sequences and randomized jobs against a job-level model.
module tb_aes128_job_ctrl;

    localparam int unsigned TMO = 8;

    localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT0  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT0  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] CT1  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid, s_ready, s_decrypt, s_first;
    logic [127:0] s_data, cfg_key, cfg_iv;
    logic [3:0]   cfg_mode;
    logic [15:0]  cfg_seg_len;
    logic         core_cipher_en, core_decipher_en, core_chain_en;
    logic [127:0] core_data_in, core_key, core_iv, core_data_out;
    logic [3:0]   core_mode;
    logic [15:0]  core_seg_len;
    logic         core_ready;
    logic         m_valid, m_ready, m_err, busy;
    logic [127:0] m_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int en_pulses = 0;
    int both_cnt = 0;
    logic mv_prev = 1'b0;

    aes128_job_ctrl #(.TIMEOUT_CYC(TMO), .TMO_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_decrypt(s_decrypt), .s_first(s_first),
        .cfg_key(cfg_key), .cfg_mode(cfg_mode), .cfg_iv(cfg_iv), .cfg_seg_len(cfg_seg_len),
        .core_cipher_en(core_cipher_en), .core_decipher_en(core_decipher_en),
        .core_chain_en(core_chain_en), .core_data_in(core_data_in), .core_key(core_key),
        .core_mode(core_mode), .core_iv(core_iv), .core_seg_len(core_seg_len),
        .core_data_out(core_data_out), .core_ready(core_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe enable pulses and m_valid rising edges mid-cycle.
    always @(negedge clk) begin
        if (core_cipher_en || core_decipher_en) en_pulses = en_pulses + 1;
        if (core_cipher_en && core_decipher_en) both_cnt = both_cnt + 1;
        if (m_valid && !mv_prev) rise_cyc = cyc;
        mv_prev = m_valid;
    end

    // Stub aes128: the two known-answer blocks, otherwise an arbitrary mix.
    function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k,
                                            input logic dec);
        if (!dec && k == KEY0 && d == PT0) return CT0;
        if ( dec && k == KEY0 && d == CT1) return PT1;
        return {d[63:0], d[127:64]} ^ k ^ {128{dec}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_s_ready"}, 128'(s_ready), 128'd1);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_m_valid"}, 128'(m_valid), 128'd0);
        check({tag, "_m_err"}, 128'(m_err), 128'd0);
        check({tag, "_m_data"}, m_data, 128'd0);
        check({tag, "_enables"}, 128'({core_cipher_en, core_decipher_en, core_chain_en}), 128'd0);
        check({tag, "_core_data_in"}, core_data_in, 128'd0);
        check({tag, "_core_key"}, core_key, 128'd0);
        check({tag, "_core_iv"}, core_iv, 128'd0);
        check({tag, "_mode_seg"}, 128'({core_mode, core_seg_len}), 128'd0);
    endtask

    // One full job; entered and left at a negedge with the DUT idle.
    // dly = cycles until the stub core raises ready (0 = never); bp = m_ready hold-off cycles.
    task automatic run_job(input string name, input logic [127:0] data, input logic [127:0] key,
                           input logic [3:0] mode, input logic [127:0] iv, input logic [15:0] seg,
                           input logic dec, input logic first, input int dly, input int bp,
                           input logic [127:0] exp_data, input logic exp_err);
        int c0, ep0, bc0, n, exp_lat;
        exp_lat = exp_err ? int'(TMO) + 1 : dly + 1;
        ep0 = en_pulses;
        bc0 = both_cnt;
        check({name, "_idle_ready"}, 128'(s_ready), 128'd1);
        s_valid = 1'b1; s_data = data; cfg_key = key; cfg_mode = mode; cfg_iv = iv;
        cfg_seg_len = seg; s_decrypt = dec; s_first = first;
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = rnd128(); cfg_key = rnd128(); cfg_iv = rnd128();
        cfg_mode = 4'($urandom); cfg_seg_len = 16'($urandom);
        s_decrypt = 1'($urandom); s_first = 1'($urandom);
        @(negedge clk);
        c0 = cyc;
        check({name, "_start_en"}, 128'({core_cipher_en, core_decipher_en}), 128'({!dec, dec}));
        check({name, "_start_chain"}, 128'(core_chain_en), 128'(!first));
        check({name, "_start_data"}, core_data_in, data);
        check({name, "_start_key"}, core_key, key);
        check({name, "_start_iv"}, core_iv, iv);
        check({name, "_start_mode_seg"}, 128'({core_mode, core_seg_len}), 128'({mode, seg}));
        check({name, "_start_busy"}, 128'({busy, s_ready}), 128'b10);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1 core_ready = 1'b1; core_data_out = core_f(data, key, dec);
            repeat (2) @(posedge clk);
            #1 core_ready = 1'b0; core_data_out = rnd128();
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 40);
        if (!m_valid) begin
            check({name, "_m_valid_wait_expired"}, 128'(m_valid), 128'd1);
            return;
        end
        #1;
        check({name, "_latency"}, 128'(rise_cyc - c0), 128'(exp_lat));
        check({name, "_m_data"}, m_data, exp_data);
        check({name, "_m_err"}, 128'(m_err), 128'(exp_err));
        check({name, "_out_hold"}, {core_data_in[126:0], core_chain_en}, {data[126:0], !first});
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); @(negedge clk);
            check({name, "_bp_state"}, 128'({m_valid, s_ready, busy}), 128'b101);
            check({name, "_bp_data"}, m_data, exp_data);
        end
        m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        check({name, "_back_idle"}, 128'({m_valid, s_ready, busy, core_chain_en}), 128'b0100);
        check({name, "_idle_hold"}, core_data_in, data);
        #1;
        check({name, "_pulses"}, 128'(en_pulses - ep0), 128'd1);
        check({name, "_both_en"}, 128'(both_cnt - bc0), 128'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [127:0] key;
        logic         dec;
        logic         first;
        int           dly;
        int           bp;
        logic [127:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"ecb_enc",      PT0, KEY0, 1'b0, 1'b1, 3, 10, CT0,    1'b0};
        vecs[1] = '{"ecb_dec",      CT1, KEY0, 1'b1, 1'b1, 5, 0,  PT1,    1'b0};
        vecs[2] = '{"chain_job1",   PT0, KEY0, 1'b0, 1'b1, 2, 1,  CT0,    1'b0};
        vecs[3] = '{"chain_job2",   CT1, KEY0, 1'b1, 1'b0, 4, 2,  PT1,    1'b0};
        vecs[4] = '{"edge_at_tmo",  PT0, KEY0, 1'b0, 1'b0, 8, 0,  CT0,    1'b0};
        vecs[5] = '{"late_edge",    PT0, KEY0, 1'b0, 1'b1, 9, 0,  128'd0, 1'b1};
        vecs[6] = '{"watchdog",     CT1, KEY0, 1'b1, 1'b0, 0, 3,  128'd0, 1'b1};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_decrypt = 1'b0; s_first = 1'b0;
        cfg_key = '0; cfg_mode = '0; cfg_iv = '0; cfg_seg_len = '0;
        core_data_out = '0; core_ready = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].name, vecs[i].data, vecs[i].key, 4'd0, rnd128(), 16'($urandom),
                    vecs[i].dec, vecs[i].first, vecs[i].dly, vecs[i].bp,
                    vecs[i].exp_data, vecs[i].exp_err);

        // A ready pulse while idle must not start anything.
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_ignored", 128'({m_valid, s_ready, busy}), 128'b010);

        // Abort a job in WAIT with reset, then run a clean job.
        s_valid = 1'b1; s_data = PT0; cfg_key = KEY0; s_decrypt = 1'b0; s_first = 1'b0;
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_mid_wait");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("after_reset");
        run_job("post_reset", PT0, KEY0, 4'd0, rnd128(), 16'd8, 1'b0, 1'b1, 4, 1, CT0, 1'b0);

        // Randomized jobs: good result iff the core answers within the watchdog window.
        for (int j = 0; j < 40; j++) begin
            logic [127:0] d, k;
            logic         dc;
            int           dl;
            bit           ok;
            d  = rnd128();
            k  = ($urandom_range(0, 3) == 0) ? KEY0 : rnd128();
            dc = 1'($urandom);
            dl = int'($urandom_range(0, 11));
            ok = (dl != 0) && (dl <= int'(TMO));
            run_job($sformatf("rand%0d", j), d, k, 4'($urandom_range(0, 4)), rnd128(),
                    16'($urandom), dc, 1'($urandom), dl, int'($urandom_range(0, 3)),
                    ok ? core_f(d, k, dc) : 128'd0, !ok);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
